// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Purpose  : UART receive front end. Oversamples the serial rx pin with a
//            16x baud strobe, deserialises 8N1 frames (LSB first) and queues
//            completed bytes in a show-ahead byte FIFO drained by MMIO reads.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk        in   core clock
//   Rst        in   asynchronous active-high reset
//   baud_tick  in   one-clk strobe at OVS x baud rate
//   rx         in   asynchronous serial input, idles high
//   rd_en      in   pop head entry (ignored while empty)
//   clr_err    in   clear sticky error flags
//   rd_data    out  FIFO head byte (0 while empty)
//   empty      out  FIFO has no entries
//   full       out  FIFO holds DEPTH entries
//   count      out  current occupancy
//   overrun    out  sticky: byte arrived while full and was dropped
//   frame_err  out  sticky: stop bit sampled low
//   rx_busy    out  receiver is mid-frame
//   parity_err out  sticky: even-parity mismatch (UART_RX_PARITY_EN only)
// Build option:
//   UART_RX_PARITY_EN - when defined, frames are 8E1 with a parity bit
//                       between the data bits and the stop bit.
// ============================================================================
module uart_rx_fifo #(
  parameter int DEPTH       = 16,
  parameter int OVS         = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     Rst,
  input  logic                     baud_tick,
  input  logic                     rx,
  input  logic                     rd_en,
  input  logic                     clr_err,
  output logic [7:0]               rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overrun,
  output logic                     frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                     parity_err,
`endif
  output logic                     rx_busy
);

  localparam int c_addr_w = $clog2(DEPTH);
  localparam int c_tick_w = (OVS > 1) ? $clog2(OVS) : 1;
  localparam logic [c_tick_w-1:0] c_tick_mid  = c_tick_w'(OVS/2 - 1);
  localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(OVS - 1);
  localparam logic [c_addr_w:0]   c_full      = (c_addr_w+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  // --------------------------------------------------------------------------
  // rx synchroniser (resets to the idle level so reset never looks like a
  // start bit)
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_rxs;

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) r_sync <= '1;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
  end

  assign w_rxs = r_sync[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // Receiver FSM
  // --------------------------------------------------------------------------
  state_t                r_state, w_state_nxt;
  logic [c_tick_w-1:0]   r_tick,  w_tick_nxt;
  logic [2:0]            r_bit,   w_bit_nxt;
  logic [7:0]            r_shreg, w_shreg_nxt;
  logic                  w_push;
  logic                  w_ferr_set;
`ifdef UART_RX_PARITY_EN
  logic                  w_perr_set;
`endif

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      r_state <= S_IDLE;
      r_tick  <= '0;
      r_bit   <= '0;
      r_shreg <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tick  <= w_tick_nxt;
      r_bit   <= w_bit_nxt;
      r_shreg <= w_shreg_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick;
    w_bit_nxt   = r_bit;
    w_shreg_nxt = r_shreg;
    w_push      = 1'b0;
    w_ferr_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_perr_set  = 1'b0;
`endif
    if (baud_tick) begin
      case (r_state)
        S_IDLE: begin
          if (!w_rxs) begin
            w_state_nxt = S_START;
            w_tick_nxt  = '0;
          end
        end
        S_START: begin
          // Re-check the line half a bit in; a high level means a glitch.
          if (r_tick == c_tick_mid) begin
            w_tick_nxt = '0;
            if (!w_rxs) begin
              w_state_nxt = S_DATA;
              w_bit_nxt   = '0;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_tick_nxt = r_tick + 1'b1;
          end
        end
        S_DATA: begin
          if (r_tick == c_tick_last) begin
            w_tick_nxt          = '0;
            w_shreg_nxt[r_bit]  = w_rxs;
            w_bit_nxt           = r_bit + 3'd1;
            if (r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              w_state_nxt = S_PARITY;
`else
              w_state_nxt = S_STOP;
`endif
            end
          end else begin
            w_tick_nxt = r_tick + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (r_tick == c_tick_last) begin
            w_tick_nxt  = '0;
            // Even parity: data ones plus the parity bit must be even.
            w_perr_set  = ^{r_shreg, w_rxs};
            w_state_nxt = S_STOP;
          end else begin
            w_tick_nxt = r_tick + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (r_tick == c_tick_last) begin
            w_tick_nxt  = '0;
            w_push      = w_rxs;
            w_ferr_set  = ~w_rxs;
            w_state_nxt = S_IDLE;
          end else begin
            w_tick_nxt = r_tick + 1'b1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign rx_busy = (r_state != S_IDLE);

  // --------------------------------------------------------------------------
  // Show-ahead FIFO with one extra pointer bit to tell full from empty
  // --------------------------------------------------------------------------
  logic [7:0]          r_mem [DEPTH];
  logic [c_addr_w:0]   r_wr_ptr, r_rd_ptr;
  logic                w_pop, w_wr, w_ovr_set;

  assign count = r_wr_ptr - r_rd_ptr;
  assign empty = (count == '0);
  assign full  = (count == c_full);

  assign w_pop     = rd_en & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_wr      = w_push & (~full | w_pop);
  assign w_ovr_set = w_push & full & ~w_pop;

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr[c_addr_w-1:0]] <= r_shreg;
  end

  assign rd_data = empty ? 8'h00 : r_mem[r_rd_ptr[c_addr_w-1:0]];

  // --------------------------------------------------------------------------
  // Sticky error flags; a new error wins over a simultaneous clear
  // --------------------------------------------------------------------------
  logic r_overrun, r_frame_err;

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_overrun   <= (r_overrun   & ~clr_err) | w_ovr_set;
      r_frame_err <= (r_frame_err & ~clr_err) | w_ferr_set;
    end
  end

  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;

`ifdef UART_RX_PARITY_EN
  logic r_parity_err;

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) r_parity_err <= 1'b0;
    else     r_parity_err <= (r_parity_err & ~clr_err) | w_perr_set;
  end

  assign parity_err = r_parity_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo
// Purpose  : Self-checking bench for uart_rx_fifo. Frames are driven on rx,
//            expected bytes are queued in a reference FIFO model, and a
//            monitor drains the DUT and compares against that queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

  localparam int DEPTH       = 16;
  localparam int OVS         = 16;
  localparam int SYNC_STAGES = 2;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS  = 11;
`else
  localparam int FRAME_BITS  = 10;
`endif
  // Busy ticks from the start-bit detection to the stop-bit sample.
  localparam int STOP_TICK_NUM = OVS/2 + (FRAME_BITS-1)*OVS;

  logic                   clk = 1'b0;
  logic                   Rst = 1'b1;
  logic                   baud_tick = 1'b0;
  logic                   rx = 1'b1;
  logic                   clr_err = 1'b0;
  logic                   mon_rd = 1'b0;
  logic                   dir_rd = 1'b0;
  logic                   rd_en;
  logic [7:0]             rd_data;
  logic                   empty, full, overrun, frame_err, rx_busy;
  logic [$clog2(DEPTH):0] count;
`ifdef UART_RX_PARITY_EN
  logic                   parity_err;
`endif

  assign rd_en = mon_rd | dir_rd;

  uart_rx_fifo #(.DEPTH(DEPTH), .OVS(OVS), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk       (clk),
    .Rst       (Rst),
    .baud_tick (baud_tick),
    .rx        (rx),
    .rd_en     (rd_en),
    .clr_err   (clr_err),
    .rd_data   (rd_data),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overrun   (overrun),
    .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  // One baud strobe every third clock.
  initial begin
    forever begin
      repeat (2) @(posedge clk);
      #1 baud_tick = 1'b1;
      @(posedge clk);
      #1 baud_tick = 1'b0;
    end
  end

  // Reference model: bytes the FIFO should currently hold, in order.
  logic [7:0] model[$];
  bit         exp_ovr  = 1'b0;
  bit         exp_ferr = 1'b0;
  bit         drain_en = 1'b0;
  int         n_vec = 0;
  int         n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops whenever the DUT shows data and draining is enabled.
  initial begin
    forever begin
      @(negedge clk);
      mon_rd = 1'b0;
      if (drain_en && !empty && !Rst) begin
        if (model.size() == 0) begin
          chk("drain_unexpected_byte", {24'h0, rd_data}, 32'hFFFF_FFFF);
        end else begin
          chk("drain_data", {24'h0, rd_data}, {24'h0, model.pop_front()});
        end
        mon_rd = 1'b1;
      end
    end
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (baud_tick !== 1'b1) @(posedge clk);
    end
    #2;
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    wait_ticks(OVS);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit pop_at_push);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^b);
`endif
    // Model update before the DUT can sample the stop bit.
    if (stop_ok) begin
      if (model.size() < DEPTH || pop_at_push) model.push_back(b);
      else exp_ovr = 1'b1;
    end else begin
      exp_ferr = 1'b1;
    end
    send_bit(stop_ok);
    send_bit(1'b1);
  endtask

  // Returns at the negedge just before the clock edge that samples the stop bit.
  task automatic wait_stop_tick(output bit ok);
    int c = 0;
    ok = 1'b0;
    for (int i = 0; i < 3*OVS*(FRAME_BITS+2)*4; i++) begin
      @(negedge clk);
      if (baud_tick && rx_busy) c++;
      if (c == STOP_TICK_NUM) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 400 && model.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk({tag, ":drained"}, model.size(), 0);
  endtask

  task automatic check_status(input string tag);
    @(negedge clk);
    chk({tag, ":count"},     count,     model.size());
    chk({tag, ":empty"},     empty,     model.size() == 0);
    chk({tag, ":full"},      full,      model.size() == DEPTH);
    chk({tag, ":overrun"},   overrun,   exp_ovr);
    chk({tag, ":frame_err"}, frame_err, exp_ferr);
    chk({tag, ":rx_busy"},   rx_busy,   0);
`ifdef UART_RX_PARITY_EN
    chk({tag, ":parity_err"}, parity_err, 0);
`endif
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    exp_ovr  = 1'b0;
    exp_ferr = 1'b0;
  endtask

  initial begin
    #(90000 * 10);
    $display("FAIL timeout: bench did not complete");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "timeout");
  end

  initial begin
    bit ok;
    logic [7:0] b;

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    chk("rst:count",     count,     0);
    chk("rst:empty",     empty,     1);
    chk("rst:full",      full,      0);
    chk("rst:rd_data",   rd_data,   0);
    chk("rst:overrun",   overrun,   0);
    chk("rst:frame_err", frame_err, 0);
    chk("rst:rx_busy",   rx_busy,   0);
    Rst = 1'b0;
    wait_ticks(OVS);

    // ---------------- single byte with push latency ----------------
    fork
      send_frame(8'h61, 1'b1, 1'b0);
      begin
        wait_stop_tick(ok);
        chk("single:stop_tick_seen", ok, 1);
        chk("single:empty_before", empty, 1);
        chk("single:busy_before", rx_busy, 1);
        @(negedge clk);
        chk("single:empty_after", empty, 0);
        chk("single:busy_after", rx_busy, 0);
        chk("single:rd_data", rd_data, 8'h61);
        chk("single:count", count, 1);
      end
    join
    drain_en = 1'b1;
    wait_drain("single");
    check_status("single");

    // ---------------- word stream ----------------
    for (int i = 0; i < 4; i++) send_frame(8'h61 + 8'(i), 1'b1, 1'b0);
    wait_drain("stream");
    check_status("stream");

    // ---------------- random bytes with random gaps ----------------
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1, 1'b0);
      wait_ticks(OVS * $urandom_range(0, 2));
    end
    wait_drain("random");
    check_status("random");

    // ---------------- overrun ----------------
    drain_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) send_frame(8'(i), 1'b1, 1'b0);
    check_status("fill");
    send_frame(8'h10, 1'b1, 1'b0);
    check_status("overrun");
    drain_en = 1'b1;
    wait_drain("overrun");
    pulse_clr();
    check_status("overrun_clr");

    // ---------------- simultaneous push and pop while full ----------------
    drain_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) send_frame(8'(i), 1'b1, 1'b0);
    fork
      send_frame(8'h10, 1'b1, 1'b1);
      begin
        wait_stop_tick(ok);
        chk("simul:stop_tick_seen", ok, 1);
        chk("simul:head", rd_data, model[0]);
        void'(model.pop_front());
        dir_rd = 1'b1;
        @(negedge clk);
        dir_rd = 1'b0;
        chk("simul:count", count, DEPTH);
        chk("simul:overrun", overrun, 0);
      end
    join
    check_status("simul");
    drain_en = 1'b1;
    wait_drain("simul");
    check_status("simul_drained");

    // ---------------- start-bit glitch ----------------
    rx = 1'b0;
    wait_ticks(3);
    chk("glitch:busy_during", rx_busy, 1);
    wait_ticks(1);
    rx = 1'b1;
    wait_ticks(OVS);
    check_status("glitch");

    // ---------------- framing error ----------------
    send_frame(8'h55, 1'b0, 1'b0);
    wait_ticks(OVS);
    check_status("frame_err");
    pulse_clr();
    check_status("frame_err_clr");

    // ---------------- reset mid-frame ----------------
    drain_en = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    send_bit(1'b0);
    b = 8'hA5;
    for (int i = 0; i < 4; i++) send_bit(b[i]);
    @(negedge clk);
    Rst = 1'b1;
    #1;
    chk("midrst:count",   count,   0);
    chk("midrst:empty",   empty,   1);
    chk("midrst:rx_busy", rx_busy, 0);
    model.delete();
    rx = 1'b1;
    repeat (5) @(negedge clk);
    Rst = 1'b0;
    wait_ticks(OVS);
    send_frame(8'h3C, 1'b1, 1'b0);
    check_status("after_rst");
    drain_en = 1'b1;
    wait_drain("after_rst");
    check_status("after_rst_drained");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
UART receive front end for the core's UART MMIO peripheral. It samples the serial `rx` pin using a 16x baud tick and deserialises 8N1 frames, LSB first. Completed bytes go into a show-ahead byte FIFO. The MMIO read path drains that FIFO, which is how host-sent words (big-endian byte order) reach software.

Parameters:
DEPTH, 16, FIFO entries; power of two, at least 2
OVS, 16, baud_tick pulses per bit period
SYNC_STAGES, 2, rx synchroniser flops

Ports:
clk  in  1  core clock (50 MHz domain)
Rst  in  1  reset
baud_tick  in  1  one-clk strobe at 16x baud rate
rx  in  1  asynchronous serial input; idles high
rd_en  in  1  pop head entry (ignored while empty)
clr_err  in  1  clears sticky error flags
rd_data  out  8  FIFO head byte, valid whenever empty=0
empty  out  1  FIFO has no entries
full  out  1  FIFO holds DEPTH entries
count  out  $clog2(DEPTH)+1  current occupancy
overrun  out  1  sticky; a byte arrived while full and was dropped
frame_err  out  1  sticky; a stop bit sampled 0
rx_busy  out  1  receiver is not in IDLE

Behaviour:
- Reset Rst: asynchronous, active-high. Everything clears:
  - synchroniser flops to 1
  - FSM to IDLE; bit and tick counters to 0
  - FIFO pointers to 0; count=0, empty=1, full=0
  - rd_data=0, overrun=0, frame_err=0, rx_busy=0
- Reset mid-frame: the partial byte is discarded and all FIFO contents are lost.
- rx passes through a SYNC_STAGES-flop synchroniser. Only the synchronised value (rxs) is used below.
- All FSM activity advances only on cycles where baud_tick=1. tick_cnt is 0..OVS-1.
- FSM states:
  - IDLE: if rxs=0, go to START with tick_cnt=0.
  - START: on tick_cnt=OVS/2-1 (midpoint), if rxs=0 go to DATA with tick_cnt=0 and bit_idx=0. Otherwise it was a glitch: return to IDLE with no push and no error.
  - DATA: on tick_cnt=OVS-1, shift rxs into shreg[bit_idx] (LSB first). After bit 7 is sampled, go to STOP.
  - STOP: on tick_cnt=OVS-1, sample rxs.
    - rxs=1: push shreg, then go to IDLE.
    - rxs=0: no push, set frame_err, go to IDLE. The receiver then waits for rx to go high only implicitly: IDLE rearms on the next low sample.
- Push latency: the byte is visible (empty=0, rd_data valid) on the clk edge after the stop-sample tick cycle.
- FIFO is show-ahead: rd_data is combinationally the head entry; a pop takes effect at the next edge.
- Push while full with no pop in the same cycle: byte dropped, overrun set, FIFO unchanged.
- Push and pop in the same cycle while full: both take effect, count is unchanged, no overrun.
- Push and pop in the same cycle while empty: the push only; a pop on empty is ignored.
- Pointers wrap modulo DEPTH. count = wr_ptr - rd_ptr using extended-width pointers.
- Error flags: clr_err clears overrun and frame_err next edge. If clr_err and a new error occur in the same cycle, the set wins.
- rx_busy=1 in START, DATA and STOP.

Optional Feature:
UART_RX_PARITY_EN
- Defined:
  - Frames are 8E1: an even-parity bit is sampled in a PARITY state between DATA and STOP.
  - Adds output parity_err (1 bit, sticky, reset 0, cleared by clr_err).
  - A byte with bad parity is still pushed if its stop bit is valid, and parity_err is set.
- Undefined: 8N1 only; no PARITY state and no parity_err port.

Test Plan:
- Single byte: send 0x61 with 16 ticks/bit, 10-bit frame -> empty falls 1 clk after the stop tick; rd_data=0x61, count=1; after rd_en pulse empty=1, count=0.
- Word stream: send 0x61,0x62,0x63,0x64 back-to-back (1 idle bit between) -> pops return 0x61,0x62,0x63,0x64 in order; overrun=0, frame_err=0.
- Overrun: send 17 bytes 0x00..0x10 without reading -> after 16, full=1 and count=16; 17th sets overrun=1; pops yield 0x00..0x0F; clr_err clears overrun.
- Simultaneous full push/pop: FIFO full, assert rd_en on the 17th byte's push cycle -> count stays 16, overrun=0, last popped entry is 0x10.
- Framing and glitch:
  - rx low for 4 ticks then high -> no push, no error, rx_busy back to 0.
  - Frame 0x55 with stop bit=0 -> frame_err=1, count=0.
- Reset mid-frame: assert Rst after bit 3 of 0xA5 with 2 bytes queued -> count=0, empty=1, rx_busy=0; a following 0x3C is received correctly.
